// File: rtl/booth_pipe_sched.sv
// Scheduler for the 3-stage Booth multiplier pipeline: round-robin grant of two
// operand requesters, per-stage load strobes, tag tracking and a valid/ready
// result port with backpressure that ripples back one stage per cycle.
module booth_pipe_sched #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    output logic                 op_sel,
    output logic                 lt1,
    output logic                 lt2,
    output logic                 lt3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_tag,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_cnt
);

    logic v1, v2, v3;
    logic t1, t2, t3;
    logic last_gnt;
    logic op_sel_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic s1_free, s2_free, s3_free;
    logic gnt_any, gnt_idx;

    // Stage strobes resolve from the output backwards so a consume and a
    // refill of the same stage can happen in one cycle; reset blocks all.
    always_comb begin
        s3_free = !v3 || out_ready;
        lt3     = rst_n && v2 && s3_free;
        s2_free = !v2 || lt3;
        lt2     = rst_n && v1 && s2_free;
        s1_free = !v1 || lt2;
    end

    // Round-robin arbiter: a lone requester wins outright, a tie goes to the
    // index that did not win last time.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        if (rst_n && s1_free) begin
            case (req_valid)
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_idx = !last_gnt;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_idx = 1'b0;
                end
            endcase
        end
        req_ready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
        lt1       = |(req_valid & req_ready);
        // The operand mux keeps pointing at the last winner while idle.
        if (!rst_n) begin
            op_sel = 1'b0;
        end else if (gnt_any) begin
            op_sel = gnt_idx;
        end else begin
            op_sel = op_sel_q;
        end
    end

    // Pipeline occupancy, tags, arbitration pointer and completion counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            t1       <= 1'b0;
            t2       <= 1'b0;
            t3       <= 1'b0;
            last_gnt <= 1'b1;
            op_sel_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            v1 <= lt1 | (v1 & !lt2);
            v2 <= lt2 | (v2 & !lt3);
            v3 <= lt3 | (v3 & !out_ready);
            if (lt1) begin
                t1       <= op_sel;
                last_gnt <= op_sel;
                op_sel_q <= op_sel;
            end
            if (lt2) begin
                t2 <= t1;
            end
            if (lt3) begin
                t3 <= t2;
            end
            if (v3 && out_ready) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Result port and status.
    always_comb begin
        out_valid = v3;
        out_tag   = t3;
        busy      = v1 | v2 | v3;
        done_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_booth_pipe_sched.sv
// Directed bench for booth_pipe_sched. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A second instance with
// a 2-bit counter shares the stimulus and is used for the wrap scenario.
module tb_booth_pipe_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic       out_ready;

    logic [1:0] req_ready;
    logic       op_sel, lt1, lt2, lt3, out_valid, out_tag, busy;
    logic [7:0] done_cnt;

    logic [1:0] w_req_ready;
    logic       w_op_sel, w_lt1, w_lt2, w_lt3, w_out_valid, w_out_tag, w_busy;
    logic [1:0] w_done_cnt;

    int checks = 0;
    int passes = 0;

    booth_pipe_sched #(.CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .op_sel(op_sel), .lt1(lt1), .lt2(lt2), .lt3(lt3),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .busy(busy), .done_cnt(done_cnt)
    );

    booth_pipe_sched #(.CNT_WIDTH(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_req_ready),
        .op_sel(w_op_sel), .lt1(w_lt1), .lt2(w_lt2), .lt3(w_lt3),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_tag(w_out_tag),
        .busy(w_busy), .done_cnt(w_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b exp 00", req_ready);
        else passes++;
        checks++;
        if ({lt1, lt2, lt3} !== 3'b000) $display("FAIL reset_lt got %b exp 000", {lt1, lt2, lt3});
        else passes++;
        checks++;
        if ({out_valid, busy, op_sel} !== 3'b000)
            $display("FAIL reset_status got %b exp 000", {out_valid, busy, op_sel});
        else passes++;
        checks++;
        if (done_cnt !== 8'd0) $display("FAIL reset_done_cnt got %0d exp 0", done_cnt);
        else passes++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || op_sel !== 1'b0 || lt1 !== 1'b1)
            $display("FAIL reset_first_grant got ready=%b sel=%b lt1=%b exp 01/0/1",
                     req_ready, op_sel, lt1);
        else passes++;
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_single_op();
        logic [3:0] exp_lt [0:4];
        exp_lt[0] = 4'b1000;  // {lt1,lt2,lt3,out_valid}
        exp_lt[1] = 4'b0100;
        exp_lt[2] = 4'b0010;
        exp_lt[3] = 4'b0001;
        exp_lt[4] = 4'b0000;
        do_reset();
        req_valid = 2'b01;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({lt1, lt2, lt3, out_valid} !== exp_lt[c])
                $display("FAIL single_strobes c%0d got %b exp %b", c, {lt1, lt2, lt3, out_valid}, exp_lt[c]);
            else passes++;
            if (c == 3) begin
                checks++;
                if (out_tag !== 1'b0) $display("FAIL single_tag got %b exp 0", out_tag);
                else passes++;
            end
            tick();
            req_valid = 2'b00;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt !== 8'd1)
            $display("FAIL single_end got busy=%b cnt=%0d exp 0/1", busy, done_cnt);
        else passes++;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 2'b11;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== ((k % 2) ? 2'b10 : 2'b01))
                $display("FAIL rr_grant k%0d got %b exp %b", k, req_ready, (k % 2) ? 2'b10 : 2'b01);
            else passes++;
            if (k >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 1'((k - 3) % 2))
                    $display("FAIL rr_tag k%0d got v=%b t=%b exp 1/%0d", k, out_valid, out_tag, (k - 3) % 2);
                else passes++;
            end
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'd5) $display("FAIL rr_done_cnt got %0d exp 5", done_cnt);
        else passes++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_valid = 2'b10;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b10) $display("FAIL bp_stream c%0d got %b exp 10", c, req_ready);
            else passes++;
            tick();
        end
        out_ready = 1'b0;
        for (int c = 4; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, lt1, lt2, lt3} !== 5'b00000)
                $display("FAIL bp_stall c%0d got %b exp 00000", c, {req_ready, lt1, lt2, lt3});
            else passes++;
            checks++;
            if ({out_valid, out_tag, busy} !== 3'b111 || done_cnt !== 8'd1)
                $display("FAIL bp_hold c%0d got %b cnt=%0d exp 111/1", c, {out_valid, out_tag, busy}, done_cnt);
            else passes++;
            tick();
        end
        out_ready = 1'b1;
        req_valid = 2'b00;
        for (int c = 8; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c < 11))
                $display("FAIL bp_drain c%0d got %b exp %b", c, out_valid, c < 11);
            else passes++;
            if (c == 8) begin
                checks++;
                if ({lt2, lt3} !== 2'b11) $display("FAIL bp_resume got %b exp 11", {lt2, lt3});
                else passes++;
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'd4 || busy !== 1'b0)
            $display("FAIL bp_total got cnt=%0d busy=%b exp 4/0", done_cnt, busy);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        out_ready = 1'b1;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        checks++;
        if ({lt1, lt2, lt3} !== 3'b000) $display("FAIL midrst_lt got %b exp 000", {lt1, lt2, lt3});
        else passes++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy} !== 2'b00 || done_cnt !== 8'd0)
                $display("FAIL midrst_clear c%0d got %b cnt=%0d exp 00/0", c, {out_valid, busy}, done_cnt);
            else passes++;
            tick();
        end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp_cnt [0:4];
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0;
        exp_cnt[4] = 2'd1;
        do_reset();
        out_ready = 1'b1;
        req_valid = 2'b01;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) req_valid = 2'b00;
            @(negedge clk);
            if (c >= 4) begin
                checks++;
                if (w_done_cnt !== exp_cnt[c - 4])
                    $display("FAIL wrap_cnt c%0d got %0d exp %0d", c, w_done_cnt, exp_cnt[c - 4]);
                else passes++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/booth_pipe_sched.md
Name: booth_pipe_sched

Overview:
- Clocked scheduler for the 3-stage Booth multiplier pipeline; arbitrates between two operand requesters and sequences the stage registers.
- Grants one requester per cycle with round-robin fairness.
- Generates per-stage load strobes lt1/lt2/lt3 that drive the stage registers' lt inputs.
- Carries a requester tag alongside each operation and presents results to a consumer with valid/ready backpressure.

Parameters:
- CNT_WIDTH, 8, width of the completed-operation counter done_cnt.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req_valid  input  2  bit i: requester i presents operands.
- req_ready  output  2  bit i: requester i granted this cycle; transfer when req_valid[i] && req_ready[i].
- op_sel  output  1  operand mux select into stage 1 (index of granted requester).
- lt1  output  1  load strobe, stage-1 register.
- lt2  output  1  load strobe, stage-2 register.
- lt3  output  1  load strobe, stage-3 (product) register.
- out_valid  output  1  stage 3 holds an unconsumed product.
- out_ready  input  1  consumer accepts product.
- out_tag  output  1  requester index owning the stage-3 product.
- busy  output  1  any stage occupied.
- done_cnt  output  CNT_WIDTH  products consumed since reset.

Behaviour:
Interface: one clock; reset is synchronous and active-low.

State:
- Occupancy bits v1, v2, v3.
- Tag bits t1, t2, t3.
- Round-robin pointer last_gnt.
- done_cnt.

Reset (rst_n=0 at an edge):
- v1=v2=v3=0, t*=0, last_gnt=1, done_cnt=0.
- Reset overrides everything, including a mid-pipeline op: in-flight ops are discarded and no strobe fires during the reset cycle.
- Outputs during and after reset until the first request: req_ready=00, lt*=0, out_valid=0, busy=0, op_sel=0.

Combinational free/strobe equations (all gated by rst_n=1):
- s3_free = !v3 || out_ready.
- lt3 = v2 && s3_free.
- s2_free = !v2 || lt3.
- lt2 = v1 && s2_free.
- s1_free = !v1 || lt2.

Arbitration (only when s1_free):
- Exactly one valid requester: grant it.
- Both valid: grant the index != last_gnt.
- req_ready is one-hot or zero.
- req_ready[i] depends on req_valid; never assert req_ready to a requester with req_valid=0.
- lt1 = |(req_valid & req_ready).
- op_sel = granted index; holds its previous value when no grant.

Register updates on rising edge:
- v1 <= lt1 | (v1 & !lt2); t1 <= op_sel when lt1.
- v2 <= lt2 | (v2 & !lt3); t2 <= t1 when lt2.
- v3 <= lt3 | (v3 & !(out_ready)); t3 <= t2 when lt3.
- last_gnt <= granted index when lt1.
- done_cnt += 1 when out_valid && out_ready; wraps 2^CNT_WIDTH-1 -> 0.

Outputs:
- out_valid = v3; out_tag = t3; busy = v1|v2|v3.

Timing:
- Latency: grant at edge E0 -> lt2 high in the cycle after E0 -> lt3 high in the cycle after E1 -> out_valid high after E2, i.e. 3 cycles.
- Throughput: 1 op/cycle with out_ready=1.

Stall:
- out_ready=0 with v3=1: lt3=0; stall propagates back one stage per cycle.
- Pipeline full and stalled: req_ready=00.
- A stalled stage keeps its data; no strobe fires on it.
- out_valid and out_tag stay stable until consumed.

Simultaneous events:
- Consume and refill of stage 3 in the same cycle (out_ready=1, v2=1): lt3=1, v3 stays 1, done_cnt increments.

Test Plan:
- Reset with req_valid=11 and rst_n=0 for 2 cycles -> req_ready=00, lt*=0, out_valid=0, done_cnt=0; first grant after release goes to requester 0.
- Single op: req_valid=01 for one cycle, out_ready=1 -> lt1 at cycle 0, lt2 at 1, lt3 at 2, out_valid=1 and out_tag=0 at cycle 3 for one cycle, done_cnt=1, busy low again at cycle 4.
- Both requesters continuously valid, out_ready=1, 8 cycles -> grants alternate 0,1,0,1...; out_tag sequence matches 3 cycles later; done_cnt=5 after 8 cycles (first product at cycle 3).
- Backpressure: stream requester 1, hold out_ready=0 from cycle 4 -> v1..v3 fill, req_ready=00 by cycle 5, no lt strobes while stalled, out_tag stable; release out_ready -> resumes at 1 product/cycle with no loss or duplication.
- Reset mid-operation: two ops in flight, rst_n=0 for one edge -> all v cleared, out_valid=0, discarded ops never appear, done_cnt=0.
- Counter wrap with CNT_WIDTH=2: consume 5 products -> done_cnt sequence 1,2,3,0,1.
